im_loader: RTL and testbench

// - Write-side companion to the 1 KB instruction memory: accepts a byte stream and fills IM sequentially from word 0.
// - Assembles 4 bytes into a big-endian (MIPS) word, then issues a one-cycle write strobe at the IM write port.
// - Holds the CPU (cpu_hold) while loading, so instruction fetch never sees a partially written program.

---
 rtl/im_loader_pkg.sv | 14 +
 rtl/im_loader_if.sv | 25 ++
 rtl/im_word_packer.sv | 27 ++
 rtl/im_loader.sv | 102 ++++++++++
 tb/tb_im_loader.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and IM geometry.
package im_loader_pkg;

  localparam int IM_AW          = 10;
  localparam int IM_DEPTH_WORDS = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } ld_state_t;

endpackage

// File: rtl/im_loader_if.sv
// Loader bus: host-side control/byte stream plus the IM write port and status.
interface im_loader_if #(parameter int AW = im_loader_pkg::IM_AW);
  logic          start;
  logic [AW:0]   len_words;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          busy;
  logic          cpu_hold;
  logic          done;
  logic          err;

  modport master (
    output start, len_words, byte_valid, byte_data,
    input  byte_ready, im_we, im_addr, im_wdata, busy, cpu_hold, done, err
  );

  modport slave (
    input  start, len_words, byte_valid, byte_data,
    output byte_ready, im_we, im_addr, im_wdata, busy, cpu_hold, done, err
  );
endinterface

// File: rtl/im_word_packer.sv
// Packs four bytes, MSB first, into a big-endian 32-bit word.
module im_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        push,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_full
);
  logic [1:0] byte_cnt;

  // Asserted in the cycle the fourth byte of a word is being pushed.
  assign word_full = push && (byte_cnt == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (clr) begin
      byte_cnt <= '0;
    end else if (push) begin
      word     <= {word[23:0], din};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end
endmodule

// File: rtl/im_loader.sv
// Streams a program byte-by-byte into instruction memory, holding the CPU until the load finishes.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int AW          = IM_AW,
  parameter int DEPTH_WORDS = IM_DEPTH_WORDS
) (
  input logic        clk,
  input logic        reset,
  im_loader_if.slave bus
);
  localparam logic [AW:0] MAX_LEN = (AW+1)'(DEPTH_WORDS);
  localparam logic [AW:0] ONE_LEN = (AW+1)'(1);

  ld_state_t     state;
  logic [AW-1:0] addr;
  logic [AW:0]   remaining;
  logic          byte_ready_q, im_we_q, busy_q, done_q, err_q;
  logic          push, clr, word_full;
  logic [31:0]   word;

  assign push = bus.byte_valid && byte_ready_q;
  assign clr  = (state == IDLE) && bus.start;

  im_word_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .push      (push),
    .din       (bus.byte_data),
    .word      (word),
    .word_full (word_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      addr         <= '0;
      remaining    <= '0;
      byte_ready_q <= 1'b0;
      im_we_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      im_we_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.len_words == '0) begin
              state  <= DONE;
              busy_q <= 1'b1;
              done_q <= 1'b1;
            end else if (bus.len_words > MAX_LEN) begin
              err_q <= 1'b1;
            end else begin
              state        <= LOAD;
              remaining    <= bus.len_words;
              addr         <= '0;
              busy_q       <= 1'b1;
              byte_ready_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (word_full) begin
            state        <= WRITE;
            byte_ready_q <= 1'b0;
            im_we_q      <= 1'b1;
          end
        end
        WRITE: begin
          remaining <= remaining - ONE_LEN;
          // Address stays on the last word so it never points past the program.
          if (remaining == ONE_LEN) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            addr         <= addr + 1'b1;
            state        <= LOAD;
            byte_ready_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.im_we      = im_we_q;
  assign bus.im_addr    = addr;
  assign bus.im_wdata   = word;
  assign bus.busy       = busy_q;
  assign bus.cpu_hold   = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: vector table, randomized loads vs. a byte-list model, corner sequences.
module tb_im_loader;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  im_loader_if bus ();
  im_loader dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed { logic [9:0] a; logic [31:0] d; } wr_t;
  typedef struct { int len; int gap; int exp_err; int exp_done; int exp_wr; } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor state (written only by the monitor process)
  wr_t  got[$];
  int   done_cnt = 0, err_cnt = 0, rdy_in_we = 0, hold_ne_busy = 0, we_long = 0;
  int   cyc_n = 0, start_cyc = 0, last_we_cyc = 0, last_done_cyc = 0;
  logic prev_we = 1'b0;

  logic [7:0] stim[$];

  always @(negedge clk) begin
    wr_t w;
    cyc_n++;
    if (!reset) begin
      if (bus.start && !bus.busy) start_cyc = cyc_n;
      if (bus.im_we) begin
        w.a = bus.im_addr;
        w.d = bus.im_wdata;
        got.push_back(w);
        last_we_cyc = cyc_n;
        if (bus.byte_ready) rdy_in_we++;
        if (prev_we) we_long++;
      end
      if (bus.done) begin done_cnt++; last_done_cyc = cyc_n; end
      if (bus.err) err_cnt++;
      if (bus.cpu_hold !== bus.busy) hold_ne_busy++;
    end
    prev_we = bus.im_we;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start      = 1'b0;
    bus.len_words  = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
  endtask

  task automatic rand_stim(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
  endtask

  // Run one load; poke>=0 pulses start (len 7) when that byte index is being offered.
  task automatic run_load(input string tag, input int len, input int gap_pct, input int poke,
                          input int exp_err, input int exp_done, input int exp_wr);
    int base, d0, e0, r0, idx, cyc, nbytes, hold_lo, rdy_hi, busy_hi, done_at, nw;
    bit poked;
    logic [31:0] mw;
    base = got.size(); d0 = done_cnt; e0 = err_cnt; r0 = rdy_in_we;
    idx = 0; cyc = 0; hold_lo = 0; rdy_hi = 0; busy_hi = 0; done_at = -1; poked = 0;
    nbytes = 4 * exp_wr;
    // A byte offered alongside start must not be consumed.
    bus.start = 1'b1; bus.len_words = len[10:0];
    bus.byte_valid = 1'b1; bus.byte_data = 8'hEE;
    tick();
    bus.start = 1'b0;
    while (idx < nbytes && cyc < 20000) begin
      bus.byte_valid = ($urandom_range(99) >= gap_pct);
      bus.byte_data  = stim[idx];
      if (poke >= 0 && idx == poke && !poked) begin
        bus.start = 1'b1; bus.len_words = 11'd7; poked = 1;
      end else begin
        bus.start = 1'b0;
      end
      if (!bus.cpu_hold) hold_lo++;
      if (bus.byte_valid && bus.byte_ready) idx++;
      tick(); cyc++;
    end
    bus.start = 1'b0;
    bus.byte_valid = 1'b0;
    if (nbytes == 0) begin
      for (int k = 0; k < 4; k++) begin
        bus.byte_valid = 1'b1; bus.byte_data = 8'h55;
        if (bus.byte_ready) rdy_hi++;
        if (bus.busy) busy_hi++;
        if (bus.done && done_at < 0) done_at = k;
        tick();
      end
      bus.byte_valid = 1'b0;
      chk({tag, ".rdy_stays_0"}, rdy_hi, 0);
      if (exp_err != 0) chk({tag, ".busy_stays_0"}, busy_hi, 0);
      if (exp_done != 0) chk({tag, ".done_within_2"}, (done_at >= 0 && done_at <= 1), 1);
    end else begin
      chk({tag, ".feed_timeout"}, idx, nbytes);
      chk({tag, ".hold_during_load"}, hold_lo, 0);
    end
    cyc = 0;
    while (bus.busy && cyc < 50) begin tick(); cyc++; end
    chk({tag, ".idle_timeout"}, bus.busy, 0);
    tick();
    nw = got.size() - base;
    chk({tag, ".n_writes"}, nw, exp_wr);
    chk({tag, ".done_pulses"}, done_cnt - d0, exp_done);
    chk({tag, ".err_pulses"}, err_cnt - e0, exp_err);
    chk({tag, ".rdy_in_write"}, rdy_in_we - r0, 0);
    for (int i = 0; i < exp_wr && i < nw; i++) begin
      mw = {stim[4*i], stim[4*i+1], stim[4*i+2], stim[4*i+3]};
      if (got[base+i].a !== 10'(i) || got[base+i].d !== mw) begin
        chk({tag, ".word_addr"}, got[base+i].a, 10'(i));
        chk({tag, ".word_data"}, got[base+i].d, mw);
        break;
      end
    end
  endtask

  vec_t tbl[8];

  initial begin
    int base, len, cyc;
    idle_inputs();
    reset = 1'b1;
    tick();
    // Reset state
    chk("rst.byte_ready", bus.byte_ready, 0);
    chk("rst.im_we",      bus.im_we, 0);
    chk("rst.busy",       bus.busy, 0);
    chk("rst.cpu_hold",   bus.cpu_hold, 0);
    chk("rst.done",       bus.done, 0);
    chk("rst.err",        bus.err, 0);
    chk("rst.im_addr",    bus.im_addr, 0);
    chk("rst.im_wdata",   bus.im_wdata, 0);
    tick();
    reset = 1'b0;
    tick();

    // Reference program word, back-to-back bytes: latency and done timing
    stim.delete();
    stim.push_back(8'h3C); stim.push_back(8'h08); stim.push_back(8'h10); stim.push_back(8'h01);
    base = got.size();
    run_load("mips1", 1, 0, -1, 0, 1, 1);
    if (got.size() > base) chk("mips1.wdata", got[base].d, 32'h3C081001);
    chk("mips1.first_we_latency", last_we_cyc - start_cyc, 5);
    chk("mips1.done_after_we", last_done_cyc - last_we_cyc, 1);

    // Three words back-to-back: 5 cycles per word
    rand_stim(12);
    run_load("b2b3", 3, 0, -1, 0, 1, 3);
    chk("b2b3.last_we_cycle", last_we_cyc - start_cyc, 15);

    // Vector table
    tbl[0] = '{1,    0,  0, 1, 1};
    tbl[1] = '{3,    40, 0, 1, 3};
    tbl[2] = '{0,    0,  0, 1, 0};
    tbl[3] = '{257,  0,  1, 0, 0};
    tbl[4] = '{2047, 0,  1, 0, 0};
    tbl[5] = '{256,  0,  0, 1, 256};
    tbl[6] = '{5,    70, 0, 1, 5};
    tbl[7] = '{2,    20, 0, 1, 2};
    foreach (tbl[i]) begin
      rand_stim(4 * tbl[i].exp_wr);
      run_load($sformatf("vec%0d", i), tbl[i].len, tbl[i].gap, -1,
               tbl[i].exp_err, tbl[i].exp_done, tbl[i].exp_wr);
    end

    // Randomized loads; expectations follow from the length rule alone
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(0, 300);
      rand_stim(len <= 256 ? 4 * len : 0);
      run_load($sformatf("rnd%0d", r), len, $urandom_range(0, 60), -1,
               (len > 256) ? 1 : 0, (len <= 256) ? 1 : 0, (len <= 256) ? len : 0);
    end

    // start pulsed mid-load is ignored
    rand_stim(8);
    run_load("poke", 2, 10, 2, 0, 1, 2);

    // byte_valid while idle: nothing consumed, no state change
    cyc = 0;
    base = got.size();
    for (int k = 0; k < 3; k++) begin
      bus.byte_valid = 1'b1; bus.byte_data = 8'hAA;
      if (bus.byte_ready || bus.busy) cyc++;
      tick();
    end
    bus.byte_valid = 1'b0;
    chk("idlebyte.rdy_busy", cyc, 0);
    chk("idlebyte.no_write", got.size() - base, 0);

    // Asynchronous reset after 2 bytes of word 1
    rand_stim(8);
    base = got.size();
    bus.start = 1'b1; bus.len_words = 11'd2;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bus.byte_valid = 1'b1; bus.byte_data = stim[k];
      cyc = 0;
      while (!bus.byte_ready && cyc < 10) begin tick(); cyc++; end
      tick();
    end
    bus.byte_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst.busy",       bus.busy, 0);
    chk("arst.cpu_hold",   bus.cpu_hold, 0);
    chk("arst.byte_ready", bus.byte_ready, 0);
    chk("arst.im_we",      bus.im_we, 0);
    chk("arst.im_addr",    bus.im_addr, 0);
    chk("arst.im_wdata",   bus.im_wdata, 0);
    chk("arst.writes_before", got.size() - base, 1);
    if (got.size() > base)
      chk("arst.word0", got[base].d, {stim[0], stim[1], stim[2], stim[3]});
    tick();
    tick();
    chk("arst.no_write_in_reset", got.size() - base, 1);
    reset = 1'b0;
    tick();
    rand_stim(4);
    run_load("reload", 1, 0, -1, 0, 1, 1);

    chk("inv.we_single_cycle", we_long, 0);
    chk("inv.hold_eq_busy", hold_ne_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
